// File: rtl/frame_packer_param.sv
// Parametrised serialising frame packer: FIFO-buffered words wrapped as SYNC|COUNT|DATA|CRC8 and
// streamed MSB-first over a bit-level valid/ready link.
module frame_packer_param #(
  parameter int unsigned       DATA_W     = 32,
  parameter int unsigned       FIFO_DEPTH = 4,
  parameter int unsigned       SYNC_W     = 8,
  parameter logic [SYNC_W-1:0] SYNC_WORD  = 8'hA5,
  parameter bit                CRC_EN     = 1'b1,
  localparam int unsigned      LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk_sys,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              tx_bit,
  output logic              tx_bit_valid,
  input  logic              tx_bit_ready,
  output logic [7:0]        frame_count,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              overflow
);

  localparam int unsigned FRAME_W = SYNC_W + 8 + DATA_W + (CRC_EN ? 8 : 0);
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = 7;

  typedef enum logic [2:0] {StIdle, StSync, StHdr, StData, StCrc} state_e;

  logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]   level_q;
  logic               overflow_q;

  state_e             state_q;
  logic [FRAME_W-1:0] sh_q, load_frame;
  logic [CNT_W-1:0]   cnt_q, field_last;
  logic [7:0]         crc_q, crc_nxt, fc_q, fc_inc, load_cnt;
  logic               valid_q;

  logic push, pop, fifo_empty, hs, field_end, frame_end, crc_fb;

  always_comb begin
    din_ready  = (level_q != LVL_W'(FIFO_DEPTH));
    fifo_empty = (level_q == '0);
    push       = din_valid && din_ready;
    hs         = valid_q && tx_bit_ready;

    case (state_q)
      StSync:  field_last = CNT_W'(SYNC_W - 1);
      StData:  field_last = CNT_W'(DATA_W - 1);
      default: field_last = CNT_W'(7);
    endcase
    field_end = hs && (cnt_q == field_last);
    frame_end = field_end && (CRC_EN ? (state_q == StCrc) : (state_q == StData));
    // Zero-gap streaming: the next word is popped on the last handshake of the current frame.
    pop       = !fifo_empty && ((state_q == StIdle) || frame_end);

    crc_fb  = crc_q[7] ^ sh_q[FRAME_W-1];
    crc_nxt = {crc_q[6:0], 1'b0} ^ (crc_fb ? 8'h07 : 8'h00);

    fc_inc   = fc_q + 8'd1;
    load_cnt = (state_q == StIdle) ? fc_q : fc_inc;

    load_frame = '0;
    load_frame[FRAME_W-1 -: SYNC_W]        = SYNC_WORD;
    load_frame[FRAME_W-SYNC_W-1 -: 8]      = load_cnt;
    load_frame[FRAME_W-SYNC_W-9 -: DATA_W] = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk_sys) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      level_q <= level_q + 1'b1;
      else if (!push && pop) level_q <= level_q - 1'b1;
      if (din_valid && !din_ready) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sh_q    <= '0;
      cnt_q   <= '0;
      crc_q   <= '0;
      fc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (pop) begin
            sh_q    <= load_frame;
            cnt_q   <= '0;
            crc_q   <= '0;
            state_q <= StSync;
            valid_q <= 1'b1;
          end
        end
        default: begin
          if (hs) begin
            sh_q  <= {sh_q[FRAME_W-2:0], 1'b0};
            cnt_q <= field_end ? '0 : cnt_q + 1'b1;
            if (state_q == StHdr || state_q == StData) crc_q <= crc_nxt;
            if (frame_end) begin
              fc_q <= fc_inc;
              if (pop) begin
                sh_q    <= load_frame;
                crc_q   <= '0;
                state_q <= StSync;
              end else begin
                state_q <= StIdle;
                valid_q <= 1'b0;
              end
            end else if (field_end) begin
              case (state_q)
                StSync: state_q <= StHdr;
                StHdr:  state_q <= StData;
                StData: begin
                  // CRC includes the data bit accepted this cycle.
                  state_q <= StCrc;
                  sh_q    <= {crc_nxt, {(FRAME_W - 8){1'b0}}};
                end
                default: state_q <= StIdle;
              endcase
            end
          end
        end
      endcase
    end
  end

  assign tx_bit       = sh_q[FRAME_W-1];
  assign tx_bit_valid = valid_q;
  assign frame_count  = fc_q;
  assign fifo_level   = level_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_frame_packer_param.sv
// Scoreboard bench for frame_packer_param: expected frame bits are queued on each accepted write
// and compared as the serial link hands them over.
module tb_frame_packer_param;

  logic        clk_sys = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] din = '0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic        tx_bit, tx_bit_valid;
  logic        tx_bit_ready = 1'b0;
  logic [7:0]  frame_count;
  logic [2:0]  fifo_level;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  bit exp_q[$];
  logic [7:0] mf = '0;
  int hs_cnt = 0;
  int rises = 0;
  logic prev_valid = 1'b0, prev_stall = 1'b0, prev_bit = 1'b0;

  always #5 clk_sys = ~clk_sys;

  frame_packer_param dut (
    .clk_sys      (clk_sys),
    .rst_n        (rst_n),
    .din          (din),
    .din_valid    (din_valid),
    .din_ready    (din_ready),
    .tx_bit       (tx_bit),
    .tx_bit_valid (tx_bit_valid),
    .tx_bit_ready (tx_bit_ready),
    .frame_count  (frame_count),
    .fifo_level   (fifo_level),
    .overflow     (overflow)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    c = crc ^ b;
    for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    return c;
  endfunction

  task automatic push_frame(input logic [7:0] cnt, input logic [31:0] d);
    logic [7:0]  sync;
    logic [39:0] body;
    logic [7:0]  crc;
    sync = 8'hA5;
    body = {cnt, d};
    crc  = 8'h00;
    for (int i = 4; i >= 0; i--) crc = crc8_byte(crc, body[i*8 +: 8]);
    for (int i = 7; i >= 0; i--) exp_q.push_back(sync[i]);
    for (int i = 39; i >= 0; i--) exp_q.push_back(body[i]);
    for (int i = 7; i >= 0; i--) exp_q.push_back(crc[i]);
  endtask

  // Monitor samples on the falling edge; a handshake seen here completes on the next rising edge.
  always @(negedge clk_sys) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (prev_stall) check("stall_hold", {62'b0, tx_bit_valid, tx_bit}, {62'b0, 1'b1, prev_bit});
      if (tx_bit_valid && !prev_valid) rises++;
      if (tx_bit_valid && tx_bit_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) check("extra_bit", 64'(exp_q.size()), 64'd1);
        else check("bit", {63'b0, tx_bit}, {63'b0, exp_q.pop_front()});
      end
      prev_stall = tx_bit_valid && !tx_bit_ready;
      prev_bit   = tx_bit;
      prev_valid = tx_bit_valid;
    end
  end

  task automatic write_word(input logic [31:0] d, output bit acc);
    din       = d;
    din_valid = 1'b1;
    @(negedge clk_sys);
    acc = din_ready;
    @(posedge clk_sys);
    #1 din_valid = 1'b0;
  endtask

  task automatic drain(input int max, input bit rnd);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      @(posedge clk_sys);
      #1 if (rnd) tx_bit_ready = 1'($urandom_range(0, 1));
      n++;
    end
    tx_bit_ready = 1'b1;
    check("drain", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    din_valid = 1'b0;
    exp_q.delete();
    mf = '0;
    repeat (2) @(posedge clk_sys);
    #1 rst_n = 1'b1;
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_din_ready"}, {63'b0, din_ready}, 64'd1);
    check({pfx, "_tx_bit"}, {63'b0, tx_bit}, 64'd0);
    check({pfx, "_tx_valid"}, {63'b0, tx_bit_valid}, 64'd0);
    check({pfx, "_frame_count"}, {56'b0, frame_count}, 64'd0);
    check({pfx, "_fifo_level"}, {61'b0, fifo_level}, 64'd0);
    check({pfx, "_overflow"}, {63'b0, overflow}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bit acc;
    int h0, r0, n, guard;
    logic [31:0] d;

    repeat (3) @(posedge clk_sys);
    #1 check_reset_vals("rst");
    rst_n = 1'b1;

    // T1: single word, sink always ready
    tx_bit_ready = 1'b1;
    h0 = hs_cnt;
    r0 = rises;
    write_word(32'hAABBCCDD, acc);
    check("t1_acc", {63'b0, acc}, 64'd1);
    push_frame(mf, 32'hAABBCCDD);
    mf++;
    @(negedge clk_sys);
    check("t1_lat_n1", {63'b0, tx_bit_valid}, 64'd0);
    @(negedge clk_sys);
    check("t1_lat_n2", {63'b0, tx_bit_valid}, 64'd1);
    @(posedge clk_sys);
    #1 drain(200, 1'b0);
    check("t1_frame_count", {56'b0, frame_count}, 64'd1);
    check("t1_valid_low", {63'b0, tx_bit_valid}, 64'd0);
    check("t1_handshakes", 64'(hs_cnt - h0), 64'd56);
    check("t1_contiguous", 64'(rises - r0), 64'd1);

    // T2: random stalls
    do_reset();
    tx_bit_ready = 1'b0;
    h0 = hs_cnt;
    write_word(32'hAABBCCDD, acc);
    check("t2_acc", {63'b0, acc}, 64'd1);
    push_frame(mf, 32'hAABBCCDD);
    mf++;
    drain(2000, 1'b1);
    check("t2_handshakes", 64'(hs_cnt - h0), 64'd56);
    check("t2_frame_count", {56'b0, frame_count}, 64'd1);

    // T3: fill against a stalled sink
    do_reset();
    tx_bit_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) check("t3_ovf_before", {63'b0, overflow}, 64'd0);
      write_word(32'h1000_0000 + 32'(i), acc);
      check("t3_acc", {63'b0, acc}, (i < 5) ? 64'd1 : 64'd0);
      if (i < 5) begin
        push_frame(mf, 32'h1000_0000 + 32'(i));
        mf++;
      end
    end
    check("t3_level", {61'b0, fifo_level}, 64'd4);
    check("t3_din_ready", {63'b0, din_ready}, 64'd0);
    check("t3_overflow", {63'b0, overflow}, 64'd1);
    tx_bit_ready = 1'b1;
    drain(2000, 1'b0);
    check("t3_ovf_sticky", {63'b0, overflow}, 64'd1);
    check("t3_frame_count", {56'b0, frame_count}, 64'd5);

    // T4: back-to-back frames
    do_reset();
    tx_bit_ready = 1'b0;
    h0 = hs_cnt;
    r0 = rises;
    for (int i = 0; i < 3; i++) begin
      d = 32'h5A00_0000 ^ 32'(i * 32'h0101_0101);
      write_word(d, acc);
      check("t4_acc", {63'b0, acc}, 64'd1);
      push_frame(mf, d);
      mf++;
    end
    check("t4_level", {61'b0, fifo_level}, 64'd2);
    tx_bit_ready = 1'b1;
    drain(1000, 1'b0);
    check("t4_handshakes", 64'(hs_cnt - h0), 64'd168);
    check("t4_contiguous", 64'(rises - r0), 64'd1);
    check("t4_frame_count", {56'b0, frame_count}, 64'd3);

    // T5: 257 frames, count wraps
    do_reset();
    tx_bit_ready = 1'b1;
    n = 0;
    guard = 0;
    while (n < 257 && guard < 30000) begin
      d = $urandom;
      write_word(d, acc);
      if (acc) begin
        push_frame(mf, d);
        mf++;
        n++;
      end
      guard++;
    end
    check("t5_written", 64'(n), 64'd257);
    drain(1000, 1'b0);
    check("t5_frame_count", {56'b0, frame_count}, 64'd1);

    // T6: reset at bit 20 of a frame
    h0 = hs_cnt;
    write_word(32'hDEADBEEF, acc);
    push_frame(mf, 32'hDEADBEEF);
    mf++;
    n = 0;
    while ((hs_cnt - h0) < 20 && n < 200) begin
      @(posedge clk_sys);
      n++;
    end
    check("t6_reach_bit20", 64'(hs_cnt - h0), 64'd20);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("t6");
    exp_q.delete();
    mf = '0;
    repeat (2) @(posedge clk_sys);
    #1 rst_n = 1'b1;
    write_word(32'h0123_4567, acc);
    check("t6_acc", {63'b0, acc}, 64'd1);
    push_frame(mf, 32'h0123_4567);
    mf++;
    drain(200, 1'b0);
    check("t6_frame_count", {56'b0, frame_count}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
